// File: rtl/clmul_seq_if.sv
// clmul_seq_if: op_enable/op_finish operand and product handshake for clmul_seq
interface clmul_seq_if #(parameter int DATA_WIDTH = 10);
  logic op_enable;
  logic [$clog2(DATA_WIDTH):0] polyn_grade;
  logic [DATA_WIDTH-1:0] a_in;
  logic [DATA_WIDTH-1:0] b_in;
  logic [2*DATA_WIDTH-1:0] out;
  logic op_finish;
  modport master(output op_enable, polyn_grade, a_in, b_in, input out, op_finish);
  modport slave(input op_enable, polyn_grade, a_in, b_in, output out, op_finish);
endinterface

// File: rtl/clmul_seq.sv
// clmul_seq: shift-and-xor GF(2) multiplier, one b bit per cycle; CLMUL_EARLY_EXIT_EN stops once remaining b is zero
module clmul_seq #(parameter int DATA_WIDTH = 10) (
  input logic clk,
  input logic rst,
  clmul_seq_if.slave bus
);
  localparam int DW = DATA_WIDTH;
  localparam int GW = $clog2(DW) + 1;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_n;
  logic [GW-1:0] m, cnt;
  logic [DW-1:0] msk, b_m, b_r;
  logic [2*DW-1:0] a_r, acc, acc_n, res;
  logic zero_load, last;
  always_comb begin
    m = bus.polyn_grade > GW'(DW) ? GW'(DW) : bus.polyn_grade;
    msk = ~({DW{1'b1}} << m);
    b_m = bus.b_in & msk;
`ifdef CLMUL_EARLY_EXIT_EN
    zero_load = b_m == '0;
    last = cnt == GW'(1) || b_r[DW-1:1] == '0;
`else
    zero_load = m == '0;
    last = cnt == GW'(1);
`endif
    acc_n = acc ^ (b_r[0] ? a_r : '0);
    state_n = state == IDLE ? (bus.op_enable ? (zero_load ? DONE : BUSY) : IDLE)
            : state == BUSY ? (!bus.op_enable ? IDLE : (last ? DONE : BUSY))
            : state == DONE ? (bus.op_enable ? DONE : IDLE) : IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      a_r <= '0;
      b_r <= '0;
      acc <= '0;
      cnt <= '0;
      res <= '0;
    end else if (state == IDLE && bus.op_enable) begin
      a_r <= {{DW{1'b0}}, bus.a_in & msk};
      b_r <= b_m;
      acc <= '0;
      cnt <= m;
      if (zero_load) res <= '0;
    end else if (state == BUSY && bus.op_enable) begin
      acc <= acc_n;
      a_r <= a_r << 1;
      b_r <= b_r >> 1;
      cnt <= cnt - GW'(1);
      if (last) res <= acc_n;
    end
  assign bus.out = res;
  assign bus.op_finish = state == DONE;
endmodule

// File: tb/tb_clmul_seq.sv
// tb_clmul_seq: directed and random jobs checked against a polynomial-product reference model
module tb_clmul_seq;
  localparam int DW = 10;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int failures = 0;
  logic [2*DW-1:0] last_want = '0;
  clmul_seq_if #(.DATA_WIDTH(DW)) bus();
  clmul_seq #(.DATA_WIDTH(DW)) dut(.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [2*DW-1:0] ref_mul(input logic [DW-1:0] a, input logic [DW-1:0] b, input int m);
    logic [2*DW-1:0] r = '0;
    for (int i = 0; i < m; i++)
      for (int j = 0; j < m; j++)
        if (a[i] && b[j]) r[i+j] = ~r[i+j];
    return r;
  endfunction
  function automatic logic [2*DW-1:0] ref_red(input logic [2*DW-1:0] p, input int m, input logic [2*DW-1:0] poly);
    logic [2*DW-1:0] r = p;
    for (int i = 2*DW-1; i >= m; i--)
      if (r[i]) r = r ^ (poly << (i - m));
    return r;
  endfunction
  function automatic int ref_lat(input logic [DW-1:0] b, input int m);
`ifdef CLMUL_EARLY_EXIT_EN
    int h = -1;
    for (int i = 0; i < m; i++)
      if (b[i]) h = i;
    return h + 1;
`else
    return m;
`endif
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask
  task automatic job(input logic [DW-1:0] a, input logic [DW-1:0] b, input int g, input int hold);
    int m;
    int lat;
    logic [2*DW-1:0] want;
    m = g > DW ? DW : g;
    want = ref_mul(a, b, m);
    lat = 0;
    @(negedge clk);
    bus.op_enable = 1'b1;
    bus.a_in = a;
    bus.b_in = b;
    bus.polyn_grade = 5'(g);
    @(posedge clk);
    #1;
    bus.a_in = DW'($urandom);
    bus.b_in = DW'($urandom);
    bus.polyn_grade = 5'($urandom);
    while (!bus.op_finish && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", lat, ref_lat(b, m));
    check("product", 32'(bus.out), 32'(want));
    repeat (hold) @(posedge clk);
    #1;
    check("hold_finish", 32'(bus.op_finish), 1);
    check("hold_out", 32'(bus.out), 32'(want));
    @(negedge clk);
    bus.op_enable = 1'b0;
    @(posedge clk);
    #1;
    check("drop_finish", 32'(bus.op_finish), 0);
    check("drop_out", 32'(bus.out), 32'(want));
    last_want = want;
  endtask
  initial begin
    rst = 1'b1;
    bus.op_enable = 1'b0;
    bus.a_in = '0;
    bus.b_in = '0;
    bus.polyn_grade = '0;
    #12;
    check("reset_out", 32'(bus.out), 0);
    check("reset_finish", 32'(bus.op_finish), 0);
    @(negedge clk);
    rst = 1'b0;
    job(10'd11, 10'd6, 4, 16);
    check("plan_58", 32'(bus.out), 58);
    check("chain_reduce", 32'(ref_red(bus.out, 4, 20'd19)), 15);
    job(10'd7, 10'd7, 3, 2);
    check("plan_21", 32'(bus.out), 21);
    job(10'd5, 10'd5, 0, 2);
    job(10'd1023, 10'd1023, 10, 1);
    check("plan_55555", 32'(bus.out), 32'h55555);
    job(10'd1023, 10'd1, 4, 1);
    check("plan_mask", 32'(bus.out), 15);
    job(DW'($urandom), 10'd4, 10, 1);
    job(DW'($urandom), DW'($urandom), 15, 1);
    @(negedge clk);
    bus.op_enable = 1'b1;
    bus.a_in = 10'd1023;
    bus.b_in = 10'd1023;
    bus.polyn_grade = 5'd10;
    repeat (5) @(posedge clk);
    @(negedge clk);
    bus.op_enable = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
      check("abort_finish", 32'(bus.op_finish), 0);
      check("abort_out", 32'(bus.out), 32'(last_want));
    end
    @(negedge clk);
    bus.op_enable = 1'b1;
    bus.a_in = 10'd1023;
    bus.b_in = 10'd1023;
    bus.polyn_grade = 5'd10;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    bus.op_enable = 1'b0;
    #1;
    check("async_rst_out", 32'(bus.out), 0);
    check("async_rst_finish", 32'(bus.op_finish), 0);
    @(negedge clk);
    rst = 1'b0;
    job(10'd11, 10'd6, 4, 1);
    for (int k = 0; k < 20; k++)
      job(DW'($urandom), DW'($urandom), int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
